// File: rtl/i2c_master_core_if.sv
// Bundle of command, FIFO and open-drain line signals between the I2C engine and its neighbours.
// No logic inside; timing is owned by the master and its partners.
// Flow control rides on tx_empty/rx_full levels and one-cycle tx_rd_en/rx_wr_en strobes.
interface i2c_master_core_if #(parameter int CW = 8);
    logic          cmd_start;
    logic [6:0]    slv_addr;
    logic          rw;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    tx_data;
    logic          tx_empty;
    logic          tx_rd_en;
    logic [7:0]    rx_data;
    logic          rx_full;
    logic          rx_wr_en;
    logic          sda_in;
    logic          sda_oe;
    logic          scl_oe;
    logic          busy;
    logic          done;
    logic          nack_err;

    modport master (
        input  cmd_start, slv_addr, rw, byte_cnt, tx_data, tx_empty, rx_full, sda_in,
        output tx_rd_en, rx_data, rx_wr_en, sda_oe, scl_oe, busy, done, nack_err
    );

    modport slave (
        output cmd_start, slv_addr, rw, byte_cnt, tx_data, tx_empty, rx_full, sda_in,
        input  tx_rd_en, rx_data, rx_wr_en, sda_oe, scl_oe, busy, done, nack_err
    );
endinterface

// File: rtl/i2c_master_core.sv
// Byte-level I2C master: pops TX FIFO bytes onto SDA/SCL, pushes received bytes into the RX FIFO.
// Each bit takes 4*QDIV PCLK cycles; START/STOP take one bit time each; a fetch adds 2 cycles.
// Empty TX FIFO or full RX FIFO stretches SCL low (clock held) until the FIFO recovers.
module i2c_master_core #(
    parameter int QDIV = 4,
    parameter int CW   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    i2c_master_core_if.master bus
);
    localparam int QW = $clog2(QDIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_FETCH, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [CW-1:0] cnt;
    logic          rw_q, ack_q, pop_pend, pushed, nack_q;
    logic [7:0]    rx_data_q;

    logic run, tick, samp, q_end;
    logic sda_oe_c, scl_oe_c, tx_rd_c, rx_wr_c, done_c;

    // The quarter counter freezes while fetching a TX byte or while the RX push is pending,
    // which is what holds SCL low during a stall.
    assign run   = (state != IDLE) && (state != WR_FETCH) && !((state == RD_ACK) && !pushed);
    assign tick  = run && (qcnt == QW'(QDIV - 1));
    assign samp  = tick && (quarter == 2'd2);
    assign q_end = tick && (quarter == 2'd3);

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state decode plus line and FIFO strobes for the current state/quarter.
    always_comb begin
        state_n  = state;
        sda_oe_c = 1'b0;
        scl_oe_c = 1'b0;
        tx_rd_c  = 1'b0;
        rx_wr_c  = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: if (bus.cmd_start) state_n = START;
            START: begin
                sda_oe_c = 1'b1;
                scl_oe_c = quarter[1];
                if (q_end) state_n = ADDR;
            end
            ADDR: begin
                sda_oe_c = ~shreg[7];
                scl_oe_c = ~quarter[1];
                if (q_end && bit_idx == 3'd7) state_n = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_oe_c = ~quarter[1];
                if (q_end) begin
                    if (ack_q || cnt == '0) state_n = STOP;
                    else if (!rw_q)         state_n = WR_FETCH;
                    else                    state_n = RD_BYTE;
                end
            end
            WR_FETCH: begin
                scl_oe_c = 1'b1;
                tx_rd_c  = !pop_pend && !bus.tx_empty;
                if (pop_pend) state_n = WR_BYTE;
            end
            WR_BYTE: begin
                sda_oe_c = ~shreg[7];
                scl_oe_c = ~quarter[1];
                if (q_end && bit_idx == 3'd7) state_n = WR_ACK;
            end
            WR_ACK: begin
                scl_oe_c = ~quarter[1];
                if (q_end) state_n = (ack_q || cnt == CW'(1)) ? STOP : WR_FETCH;
            end
            RD_BYTE: begin
                scl_oe_c = ~quarter[1];
                if (q_end && bit_idx == 3'd7) state_n = RD_ACK;
            end
            RD_ACK: begin
                scl_oe_c = ~quarter[1];
                rx_wr_c  = !pushed && !bus.rx_full;
                // ACK every byte but the last; the final byte is NACKed to end the read.
                sda_oe_c = pushed && (cnt > CW'(1));
                if (q_end) state_n = (cnt == CW'(1)) ? STOP : RD_BYTE;
            end
            STOP: begin
                sda_oe_c = (quarter != 2'd3);
                scl_oe_c = ~quarter[1];
                if (q_end) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Quarter/bit timing, shift register, byte count and status flags.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            qcnt      <= '0;
            quarter   <= 2'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            cnt       <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            pop_pend  <= 1'b0;
            pushed    <= 1'b0;
            nack_q    <= 1'b0;
            rx_data_q <= 8'd0;
        end else if (state == IDLE) begin
            qcnt     <= '0;
            quarter  <= 2'd0;
            bit_idx  <= 3'd0;
            pop_pend <= 1'b0;
            pushed   <= 1'b0;
            if (bus.cmd_start) begin
                shreg  <= {bus.slv_addr, bus.rw};
                rw_q   <= bus.rw;
                cnt    <= bus.byte_cnt;
                nack_q <= 1'b0;
            end
        end else begin
            if (tick) begin
                qcnt    <= '0;
                quarter <= quarter + 2'd1;
            end else if (run) begin
                qcnt <= qcnt + 1'b1;
            end
            case (state)
                ADDR, WR_BYTE: begin
                    if (q_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                RD_BYTE: begin
                    if (samp) shreg <= {shreg[6:0], bus.sda_in};
                    if (q_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        // Byte is complete here, so rx_data is already stable when the push fires.
                        if (bit_idx == 3'd7) rx_data_q <= shreg;
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (samp) ack_q <= bus.sda_in;
                    if (q_end && ack_q) nack_q <= 1'b1;
                    if (q_end && !ack_q && state == WR_ACK) cnt <= cnt - 1'b1;
                end
                WR_FETCH: begin
                    if (pop_pend) begin
                        shreg    <= bus.tx_data;
                        pop_pend <= 1'b0;
                    end else if (tx_rd_c) begin
                        pop_pend <= 1'b1;
                    end
                end
                RD_ACK: begin
                    if (rx_wr_c) pushed <= 1'b1;
                    if (q_end) begin
                        pushed <= 1'b0;
                        cnt    <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_c;
    assign bus.scl_oe   = scl_oe_c;
    assign bus.tx_rd_en = tx_rd_c;
    assign bus.rx_wr_en = rx_wr_c;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_c;
    assign bus.nack_err = nack_q;
endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with a bit-level I2C slave model and FIFO models.
// Runs write, read, NACK, TX/RX stall and mid-transfer reset scenarios.
// Slave ACK/read data are set per scenario; FIFO levels are driven directly.
module tb_i2c_master_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_master_core_if #(.CW(8)) bus ();
    i2c_master_core #(.QDIV(4), .CW(8)) dut (.PCLK(clk), .PRESETn(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // TX FIFO model: data valid the cycle after the pop.
    logic [7:0] tx_mem [16];
    int tx_wr_n = 0;
    int tx_rd_n = 0;
    assign bus.tx_empty = (tx_wr_n == tx_rd_n);
    always @(posedge clk) begin
        if (bus.tx_rd_en) begin
            bus.tx_data <= tx_mem[tx_rd_n % 16];
            tx_rd_n     <= tx_rd_n + 1;
        end
    end

    // RX FIFO model.
    logic [7:0] rx_log [16];
    int rx_n = 0;
    int rx_bad = 0;
    always @(posedge clk) begin
        if (bus.rx_wr_en) begin
            rx_log[rx_n % 16] <= bus.rx_data;
            rx_n <= rx_n + 1;
            if (bus.rx_full) rx_bad <= rx_bad + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model configuration (written by the test tasks).
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rd_bytes [4];
    int         rd_n = 0;

    // Slave model state and logs.
    logic       slv_rel = 1'b1;
    logic [7:0] wire_b [32];
    logic       ack_b  [32];
    int wb_n = 0, ab_n = 0, start_n = 0, stop_n = 0, rise_n = 0, done_n = 0;
    int bitn = 0, byte_idx = 0, rise1 = 0, rise2 = 0;
    logic is_read = 1'b0;
    logic [7:0] shift = 8'd0;
    logic prev_scl = 1'b1, prev_sda = 1'b1, scl_l, sda_l;

    assign bus.sda_in = ~bus.sda_oe & slv_rel;

    // Bit-level slave: decodes START/STOP, logs bytes and ACK slots, drives ACKs and read data.
    always @(negedge clk) begin
        scl_l = ~bus.scl_oe;
        sda_l = ~bus.sda_oe & slv_rel;
        if (bus.done) done_n++;
        if (prev_scl && scl_l && prev_sda && !sda_l) begin
            start_n++;
            bitn = 0; byte_idx = 0; is_read = 1'b0; slv_rel = 1'b1;
        end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
            stop_n++;
        end else if (!prev_scl && scl_l) begin
            rise_n++;
            if (byte_idx == 0 && bitn == 0) rise1 = cyc;
            if (byte_idx == 0 && bitn == 1) rise2 = cyc;
            if (bitn < 8) begin
                shift = {shift[6:0], sda_l};
                if (bitn == 7) begin
                    wire_b[wb_n % 32] = shift;
                    wb_n++;
                    if (byte_idx == 0) is_read = shift[0];
                end
                bitn++;
            end else begin
                ack_b[ab_n % 32] = sda_l;
                ab_n++;
                bitn = 0;
                byte_idx++;
            end
        end else if (prev_scl && !scl_l) begin
            if (bitn == 8)
                slv_rel = (byte_idx == 0) ? ~ack_addr : (is_read ? 1'b1 : ~ack_data);
            else if (is_read && byte_idx >= 1 && byte_idx <= rd_n)
                slv_rel = rd_bytes[byte_idx - 1][7 - bitn];
            else
                slv_rel = 1'b1;
        end
        prev_scl = scl_l;
        prev_sda = ~bus.sda_oe & slv_rel;
    end

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr_n % 16] = b;
        tx_wr_n++;
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] n);
        @(negedge clk);
        bus.slv_addr  = a;
        bus.rw        = r;
        bus.byte_cnt  = n;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, want 0", name, budget);
        end
    endtask

    task automatic test_reset();
        bus.cmd_start = 1'b0; bus.slv_addr = 7'd0; bus.rw = 1'b0;
        bus.byte_cnt = 8'd0; bus.rx_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sda_oe, bus.scl_oe, bus.tx_rd_en, bus.rx_wr_en, bus.busy, bus.done, bus.nack_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0000000",
                     {bus.sda_oe, bus.scl_oe, bus.tx_rd_en, bus.rx_wr_en, bus.busy, bus.done, bus.nack_err});
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int s_wb = wb_n, s_ab = ab_n, s_pop = tx_rd_n, s_done = done_n, s_stop = stop_n;
        ack_addr = 1'b1; ack_data = 1'b1; rd_n = 0;
        push_tx(8'h55);
        issue(7'h50, 1'b0, 8'd1);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
        wait_idle("wr", 3000);
        checks++;
        if (wire_b[s_wb % 32] !== 8'hA0) begin errors++; $display("FAIL wr_addr_byte: got %h want a0", wire_b[s_wb % 32]); end
        checks++;
        if (wire_b[(s_wb + 1) % 32] !== 8'h55) begin errors++; $display("FAIL wr_data_byte: got %h want 55", wire_b[(s_wb + 1) % 32]); end
        checks++;
        if ({ack_b[s_ab % 32], ack_b[(s_ab + 1) % 32]} !== 2'b00) begin
            errors++; $display("FAIL wr_acks: got %b want 00", {ack_b[s_ab % 32], ack_b[(s_ab + 1) % 32]});
        end
        checks++;
        if (tx_rd_n - s_pop != 1) begin errors++; $display("FAIL wr_pops: got %0d want 1", tx_rd_n - s_pop); end
        checks++;
        if (done_n - s_done != 1) begin errors++; $display("FAIL wr_done_cycles: got %0d want 1", done_n - s_done); end
        checks++;
        if (stop_n - s_stop != 1) begin errors++; $display("FAIL wr_stop: got %0d want 1", stop_n - s_stop); end
        checks++;
        if (bus.nack_err !== 1'b0) begin errors++; $display("FAIL wr_nack: got %b want 0", bus.nack_err); end
        checks++;
        if (rise2 - rise1 != 16) begin errors++; $display("FAIL wr_bit_time: got %0d want 16", rise2 - rise1); end
    endtask

    task automatic test_read();
        int s_wb = wb_n, s_ab = ab_n, s_rx = rx_n, s_pop = tx_rd_n, s_stop = stop_n;
        ack_addr = 1'b1;
        rd_bytes[0] = 8'hAA; rd_bytes[1] = 8'hFA; rd_n = 2;
        issue(7'h26, 1'b1, 8'd2);
        wait_idle("rd", 3000);
        checks++;
        if (wire_b[s_wb % 32] !== 8'h4D) begin errors++; $display("FAIL rd_addr_byte: got %h want 4d", wire_b[s_wb % 32]); end
        checks++;
        if (rx_n - s_rx != 2) begin errors++; $display("FAIL rd_pushes: got %0d want 2", rx_n - s_rx); end
        checks++;
        if (rx_log[s_rx % 16] !== 8'hAA) begin errors++; $display("FAIL rd_byte0: got %h want aa", rx_log[s_rx % 16]); end
        checks++;
        if (rx_log[(s_rx + 1) % 16] !== 8'hFA) begin errors++; $display("FAIL rd_byte1: got %h want fa", rx_log[(s_rx + 1) % 16]); end
        checks++;
        if ({ack_b[(s_ab + 1) % 32], ack_b[(s_ab + 2) % 32]} !== 2'b01) begin
            errors++; $display("FAIL rd_master_acks: got %b want 01", {ack_b[(s_ab + 1) % 32], ack_b[(s_ab + 2) % 32]});
        end
        checks++;
        if (tx_rd_n - s_pop != 0 || stop_n - s_stop != 1) begin
            errors++; $display("FAIL rd_pops_stop: got pops %0d stops %0d want 0 1", tx_rd_n - s_pop, stop_n - s_stop);
        end
        rd_n = 0;
    endtask

    task automatic test_addr_nack();
        int s_wb = wb_n, s_ab = ab_n, s_pop = tx_rd_n, s_stop = stop_n, s_start = start_n;
        int k = 0;
        ack_addr = 1'b0;
        issue(7'h11, 1'b0, 8'd1);
        while (bus.nack_err !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        checks++;
        if (bus.nack_err !== 1'b1) begin errors++; $display("FAIL nack_set: got %b want 1", bus.nack_err); end
        issue(7'h7F, 1'b1, 8'd3);
        checks++;
        if ({bus.busy, bus.nack_err} !== 2'b11) begin
            errors++; $display("FAIL nack_ignore_busy: got busy/nack %b want 11", {bus.busy, bus.nack_err});
        end
        wait_idle("nack", 1000);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || start_n - s_start != 1) begin
            errors++; $display("FAIL nack_no_restart: got busy %b starts %0d want 0 1", bus.busy, start_n - s_start);
        end
        checks++;
        if (wire_b[s_wb % 32] !== 8'h22 || ack_b[s_ab % 32] !== 1'b1) begin
            errors++; $display("FAIL nack_wire: got %h ack %b want 22 1", wire_b[s_wb % 32], ack_b[s_ab % 32]);
        end
        checks++;
        if (tx_rd_n - s_pop != 0 || stop_n - s_stop != 1 || bus.nack_err !== 1'b1) begin
            errors++; $display("FAIL nack_end: got pops %0d stops %0d nack %b want 0 1 1",
                               tx_rd_n - s_pop, stop_n - s_stop, bus.nack_err);
        end
        ack_addr = 1'b1;
        issue(7'h11, 1'b0, 8'd0);
        checks++;
        if (bus.nack_err !== 1'b0) begin errors++; $display("FAIL nack_clear: got %b want 0", bus.nack_err); end
        wait_idle("probe", 1000);
        checks++;
        if (bus.nack_err !== 1'b0 || wire_b[(s_wb + 1) % 32] !== 8'h22) begin
            errors++; $display("FAIL probe_end: got nack %b byte %h want 0 22", bus.nack_err, wire_b[(s_wb + 1) % 32]);
        end
    endtask

    task automatic test_tx_stall();
        int s_wb = wb_n, s_ab = ab_n, s_pop = tx_rd_n, s_done = done_n;
        int k = 0;
        int bad = 0;
        push_tx(8'h3C);
        issue(7'h3A, 1'b0, 8'd2);
        while (ab_n - s_ab < 2 && k < 2000) begin @(negedge clk); k++; end
        repeat (12) @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (bus.scl_oe !== 1'b1 || bus.busy !== 1'b1 || bus.tx_rd_en !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL txstall_scl_held: got %0d bad cycles want 0", bad); end
        push_tx(8'hC3);
        wait_idle("txstall", 3000);
        checks++;
        if (wire_b[s_wb % 32] !== 8'h74 || wire_b[(s_wb + 1) % 32] !== 8'h3C || wire_b[(s_wb + 2) % 32] !== 8'hC3) begin
            errors++; $display("FAIL txstall_bytes: got %h %h %h want 74 3c c3",
                               wire_b[s_wb % 32], wire_b[(s_wb + 1) % 32], wire_b[(s_wb + 2) % 32]);
        end
        checks++;
        if (tx_rd_n - s_pop != 2 || done_n - s_done != 1) begin
            errors++; $display("FAIL txstall_pops_done: got %0d %0d want 2 1", tx_rd_n - s_pop, done_n - s_done);
        end
    endtask

    task automatic test_rx_stall();
        int s_wb = wb_n, s_rx = rx_n, s_bad = rx_bad;
        int k = 0;
        int bad = 0;
        bus.rx_full = 1'b1;
        rd_bytes[0] = 8'h81; rd_bytes[1] = 8'h7E; rd_n = 2;
        issue(7'h13, 1'b1, 8'd2);
        while (wb_n - s_wb < 2 && k < 2000) begin @(negedge clk); k++; end
        repeat (12) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (bus.scl_oe !== 1'b1 || bus.rx_wr_en !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rxstall_scl_held: got %0d bad cycles want 0", bad); end
        bus.rx_full = 1'b0;
        wait_idle("rxstall", 3000);
        checks++;
        if (rx_n - s_rx != 2 || rx_bad != s_bad) begin
            errors++; $display("FAIL rxstall_pushes: got %0d (while full %0d) want 2 (0)", rx_n - s_rx, rx_bad - s_bad);
        end
        checks++;
        if (rx_log[s_rx % 16] !== 8'h81 || rx_log[(s_rx + 1) % 16] !== 8'h7E || wire_b[s_wb % 32] !== 8'h27) begin
            errors++; $display("FAIL rxstall_data: got %h %h addr %h want 81 7e 27",
                               rx_log[s_rx % 16], rx_log[(s_rx + 1) % 16], wire_b[s_wb % 32]);
        end
        rd_n = 0;
    endtask

    task automatic test_reset_mid();
        int s_rise = rise_n;
        int s_wb, s_done, s_pop, s_stop;
        int k = 0;
        issue(7'h50, 1'b0, 8'd1);
        while (rise_n - s_rise < 3 && k < 1000) begin @(negedge clk); k++; end
        k = 0;
        while (bus.scl_oe !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if ({bus.busy, bus.sda_oe, bus.scl_oe} !== 3'b111) begin
            errors++; $display("FAIL mid_bit3_drive: got busy/sda/scl %b want 111", {bus.busy, bus.sda_oe, bus.scl_oe});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.sda_oe, bus.scl_oe, bus.nack_err} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_release: got %b want 0000", {bus.busy, bus.sda_oe, bus.scl_oe, bus.nack_err});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s_wb = wb_n; s_done = done_n; s_pop = tx_rd_n; s_stop = stop_n;
        issue(7'h2A, 1'b0, 8'd0);
        wait_idle("after_reset", 1000);
        checks++;
        if (wire_b[s_wb % 32] !== 8'h54 || done_n - s_done != 1 || stop_n - s_stop != 1 || tx_rd_n != s_pop) begin
            errors++; $display("FAIL after_reset_probe: got byte %h done %0d stop %0d pops %0d want 54 1 1 0",
                               wire_b[s_wb % 32], done_n - s_done, stop_n - s_stop, tx_rd_n - s_pop);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_tx_stall();
        test_rx_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
